// File: rtl/vga_pwm_sched.sv
// Dither phase scheduler for the VGA 24->18 bit temporal-dither datapath.
// Ports: clk, reset, ce_pix, csync_en, hsync, csync, vsync, cfg_mode, cfg_load
//        in; phase, dither_en, locked, frame_cnt out.
module vga_pwm_sched #(
  parameter int FILT_LEN   = 4,
  parameter int TIMEOUT    = 4096,
  parameter int LOCK_LINES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       csync_en,
  input  logic       hsync,
  input  logic       csync,
  input  logic       vsync,
  input  logic [1:0] cfg_mode,
  input  logic       cfg_load,
  output logic [1:0] phase,
  output logic       dither_en,
  output logic       locked,
  output logic [7:0] frame_cnt
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_LINES + 1);

  typedef enum logic [1:0] {
    NOSIG,
    LOCKING,
    LOCKED
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          sel_q;
  logic          s_raw;
  logic          s_filt;
  logic          s_filt_d;
  logic [FW-1:0] fcnt;
  logic          vs_q;
  logic          vs_d;
  logic [1:0]    line_cnt;
  logic [1:0]    line_nxt;
  logic [7:0]    frame_nxt;
  logic [1:0]    mode_pend;
  logic [1:0]    mode_act;
  logic [1:0]    seed;
  logic [WW-1:0] wd;
  logic [LW-1:0] lock_cnt;
  logic [LW-1:0] lock_inc;
  logic          toggle;
  logic          line_start;
  logic          frame_start;
  logic          timeout;

  // A change of sync source invalidates all timing history.
  assign toggle      = csync_en ^ sel_q;
  assign line_start  = s_filt_d & ~s_filt;
  assign frame_start = vs_q & ~vs_d;
  assign timeout     = (wd == WW'(TIMEOUT));
  assign lock_inc    = lock_cnt + LW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q    <= 1'b0;
      s_raw    <= 1'b0;
      s_filt   <= 1'b0;
      s_filt_d <= 1'b0;
      fcnt     <= '0;
      vs_q     <= 1'b0;
      vs_d     <= 1'b0;
    end else begin
      sel_q    <= csync_en;
      s_raw    <= csync_en ? csync : hsync;
      s_filt_d <= s_filt;
      vs_q     <= vsync;
      vs_d     <= vs_q;
      if (toggle || s_raw == s_filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILT_LEN - 1)) begin
        s_filt <= s_raw;
        fcnt   <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  // Frame start wins over a coincident line start.
  always_comb begin
    line_nxt  = line_cnt;
    frame_nxt = frame_cnt;
    if (frame_start) begin
      line_nxt  = 2'd0;
      frame_nxt = frame_cnt + 8'd1;
    end else if (line_start) begin
      line_nxt = line_cnt + 2'd1;
    end
  end

  // Seed is taken from the post-update counts.
  always_comb begin
    seed = 2'd0;
    case (mode_act)
      2'd2:    seed = line_nxt;
      2'd3:    seed = line_nxt + frame_nxt[1:0];
      default: seed = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt  <= 2'd0;
      frame_cnt <= 8'd0;
      phase     <= 2'd0;
    end else begin
      line_cnt  <= line_nxt;
      frame_cnt <= frame_nxt;
      if (mode_act == 2'd0 || s_filt)
        phase <= 2'd0;
      else if (line_start)
        phase <= seed;
      else if (ce_pix)
        phase <= phase + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_pend <= 2'd0;
      mode_act  <= 2'd0;
    end else begin
      if (cfg_load)
        mode_pend <= cfg_mode;
      if (state != LOCKED)
        mode_act <= mode_pend;
      else if (frame_start)
        mode_act <= cfg_load ? cfg_mode : mode_pend;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd       <= '0;
      lock_cnt <= '0;
    end else begin
      if (toggle || line_start)
        wd <= '0;
      else if (!timeout)
        wd <= wd + WW'(1);
      if (toggle)
        lock_cnt <= '0;
      else if (line_start && state == NOSIG)
        lock_cnt <= LW'(1);
      else if (line_start && state == LOCKING)
        lock_cnt <= lock_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= NOSIG;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (toggle) begin
      state_nxt = NOSIG;
    end else if (line_start) begin
      case (state)
        NOSIG:
          state_nxt = (LOCK_LINES == 1) ? LOCKED : LOCKING;
        LOCKING:
          if (lock_inc == LW'(LOCK_LINES))
            state_nxt = LOCKED;
        default:
          state_nxt = state;
      endcase
    end else if (timeout) begin
      state_nxt = NOSIG;
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset)
      dither_en <= 1'b0;
    else
      dither_en <= (state == LOCKED) && (mode_act != 2'd0);
  end

endmodule

// File: tb/tb_vga_pwm_sched.sv
// Directed self-checking bench for vga_pwm_sched.
// Drives sync/config sequences and checks phase, lock and frame counts.
module tb_vga_pwm_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce_pix;
  logic       csync_en;
  logic       hsync;
  logic       csync;
  logic       vsync;
  logic [1:0] cfg_mode;
  logic       cfg_load;
  logic [1:0] phase;
  logic       dither_en;
  logic       locked;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  vga_pwm_sched dut (
    .clk       (clk),
    .reset     (reset),
    .ce_pix    (ce_pix),
    .csync_en  (csync_en),
    .hsync     (hsync),
    .csync     (csync),
    .vsync     (vsync),
    .cfg_mode  (cfg_mode),
    .cfg_load  (cfg_load),
    .phase     (phase),
    .dither_en (dither_en),
    .locked    (locked),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_mode(input logic [1:0] m);
    cfg_mode = m;
    cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(2);
  endtask

  // Ends one clock after line_start, when the seed has been loaded.
  task automatic hline();
    hsync = 1'b1;
    tick(6);
    hsync = 1'b0;
    tick(6);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ce_pix   = 1'b1;
    csync_en = 1'b0;
    hsync    = 1'b0;
    csync    = 1'b0;
    vsync    = 1'b0;
    cfg_mode = 2'd0;
    cfg_load = 1'b0;
    tick(3);
    reset = 1'b0;
    checks++;
    if (phase !== 2'd0) begin
      errors++;
      $display("FAIL reset_phase got %0d want 0", phase);
    end
    checks++;
    if (dither_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_dither_en got %0b want 0", dither_en);
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_locked got %0b want 0", locked);
    end
    checks++;
    if (frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt);
    end
  endtask

  task automatic test_lock();
    load_mode(2'd1);
    tick(1);
    hline();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_line1 got %0b want 0", locked);
    end
    tick(10);
    hsync = 1'b1;
    tick(6);
    hsync = 1'b0;
    tick(5);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_at_ls2 got %0b want 0", locked);
    end
    tick(1);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_after_ls2 got %0b want 1", locked);
    end
    tick(1);
    checks++;
    if (dither_en !== 1'b1) begin
      errors++;
      $display("FAIL lock_dither_en got %0b want 1", dither_en);
    end
    checks++;
    if (phase !== 2'd1) begin
      errors++;
      $display("FAIL lock_phase got %0d want 1", phase);
    end
    hsync = 1'b1;
    tick(6);
    checks++;
    if (phase !== 2'd0) begin
      errors++;
      $display("FAIL sync_phase got %0d want 0", phase);
    end
    hsync = 1'b0;
    tick(6);
    tick(2);
    checks++;
    if (phase !== 2'd2 || locked !== 1'b1) begin
      errors++;
      $display("FAIL line3 got ph=%0d lk=%0b want ph=2 lk=1",
               phase, locked);
    end
  endtask

  task automatic test_glitch();
    hsync = 1'b1;
    tick(3);
    hsync = 1'b0;
    tick(6);
    checks++;
    if (phase !== 2'd3) begin
      errors++;
      $display("FAIL glitch_phase got %0d want 3", phase);
    end
    hsync = 1'b1;
    tick(4);
    hsync = 1'b0;
    tick(3);
    checks++;
    if (phase !== 2'd0) begin
      errors++;
      $display("FAIL pulse4_sync got %0d want 0", phase);
    end
    tick(4);
    checks++;
    if (phase !== 2'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL pulse4_line got ph=%0d lk=%0b want ph=1 lk=1",
               phase, locked);
    end
  endtask

  task automatic test_seed();
    logic [1:0] want [4];
    want[0] = 2'd2;
    want[1] = 2'd3;
    want[2] = 2'd0;
    want[3] = 2'd1;
    load_mode(2'd3);
    for (int i = 0; i < 5; i++) vs_pulse();
    checks++;
    if (frame_cnt !== 8'd5) begin
      errors++;
      $display("FAIL seed_frame got %0d want 5", frame_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      hline();
      checks++;
      if (phase !== want[i]) begin
        errors++;
        $display("FAIL seed_line%0d got %0d want %0d",
                 i, phase, want[i]);
      end
      if (i == 0) begin
        ce_pix = 1'b0;
        tick(3);
        checks++;
        if (phase !== 2'd2) begin
          errors++;
          $display("FAIL ce_hold got %0d want 2", phase);
        end
        ce_pix = 1'b1;
        tick(1);
        checks++;
        if (phase !== 2'd3) begin
          errors++;
          $display("FAIL ce_step got %0d want 3", phase);
        end
      end
    end
    checks++;
    if (dither_en !== 1'b1) begin
      errors++;
      $display("FAIL seed_dither_en got %0b want 1", dither_en);
    end
  endtask

  task automatic test_mode_switch();
    load_mode(2'd0);
    tick(3);
    checks++;
    if (dither_en !== 1'b1) begin
      errors++;
      $display("FAIL pend_hold got %0b want 1", dither_en);
    end
    vsync = 1'b1;
    tick(2);
    checks++;
    if (dither_en !== 1'b1) begin
      errors++;
      $display("FAIL pend_edge got %0b want 1", dither_en);
    end
    tick(1);
    checks++;
    if (dither_en !== 1'b0 || phase !== 2'd0) begin
      errors++;
      $display("FAIL mode0 got en=%0b ph=%0d want en=0 ph=0",
               dither_en, phase);
    end
    vsync = 1'b0;
    tick(2);
    checks++;
    if (frame_cnt !== 8'd6) begin
      errors++;
      $display("FAIL mode0_frame got %0d want 6", frame_cnt);
    end
  endtask

  task automatic test_timeout();
    load_mode(2'd1);
    vs_pulse();
    hline();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL to_anchor got %0b want 1", locked);
    end
    tick(4096);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL to_edge got %0b want 1", locked);
    end
    tick(1);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL to_drop got %0b want 0", locked);
    end
    tick(1);
    checks++;
    if (dither_en !== 1'b0) begin
      errors++;
      $display("FAIL to_dither_en got %0b want 0", dither_en);
    end
    hline();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL relock1 got %0b want 0", locked);
    end
    hline();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock2 got %0b want 1", locked);
    end
    tick(1);
    checks++;
    if (dither_en !== 1'b1) begin
      errors++;
      $display("FAIL relock_en got %0b want 1", dither_en);
    end
    csync    = 1'b0;
    csync_en = 1'b1;
    tick(1);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL toggle_lock got %0b want 0", locked);
    end
    checks++;
    if (frame_cnt !== 8'd7) begin
      errors++;
      $display("FAIL toggle_frame got %0d want 7", frame_cnt);
    end
    tick(10);
    csync_en = 1'b0;
    tick(1);
  endtask

  task automatic test_back_to_back();
    load_mode(2'd3);
    tick(1);
    for (int i = 0; i < 247; i++) vs_pulse();
    checks++;
    if (frame_cnt !== 8'd254) begin
      errors++;
      $display("FAIL b2b_pre got %0d want 254", frame_cnt);
    end
    hsync = 1'b1;
    tick(6);
    hsync = 1'b0;
    tick(4);
    vsync = 1'b1;
    tick(2);
    checks++;
    if (frame_cnt !== 8'd255 || phase !== 2'd3) begin
      errors++;
      $display("FAIL b2b_same got fc=%0d ph=%0d want fc=255 ph=3",
               frame_cnt, phase);
    end
    vsync = 1'b0;
    tick(2);
    vs_pulse();
    checks++;
    if (frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_wrap got %0d want 0", frame_cnt);
    end
    hline();
    checks++;
    if (phase !== 2'd1) begin
      errors++;
      $display("FAIL b2b_seed got %0d want 1", phase);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_glitch();
    test_seed();
    test_mode_switch();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
